err_monitor: RTL and testbench

ERR_MONITOR -- requirements
Module: err_monitor

---
 rtl/err_monitor.sv | 165 ++++++++++++++++
 tb/tb_err_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/err_monitor.sv
// err_monitor: watches a processor's retire/halt/fault strobes and reports a
// sticky error or a sticky clean-halt result, plus cycle and retire counts.
//
// Ports:
//   clk           - clock, all state changes on the rising edge
//   rst_n         - asynchronous active-low reset
//   retire_valid  - one instruction retired this cycle
//   halt          - halt executed this cycle
//   illegal_instr - illegal instruction flagged this cycle
//   mem_misalign  - misaligned memory access flagged this cycle
//   pc            - current pc (only with ERR_MON_PC_CAPTURE_EN)
//   err           - sticky error flag
//   err_cause     - 0 none, 1 illegal, 2 misalign, 3 hang, 4 timeout
//   err_pc        - pc sampled on the edge entering ERROR (only with ERR_MON_PC_CAPTURE_EN)
//   done          - sticky clean-halt flag
//   cycles        - cycles spent in RUN (saturating)
//   retired       - instructions retired (saturating)
//
// Optional feature macro: ERR_MON_PC_CAPTURE_EN adds the pc / err_pc ports.
module err_monitor #(
    parameter int unsigned HANG_LIMIT = 16,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire_valid,
    input  logic        halt,
    input  logic        illegal_instr,
    input  logic        mem_misalign,
`ifdef ERR_MON_PC_CAPTURE_EN
    input  logic [31:0] pc,
    output logic [31:0] err_pc,
`endif
    output logic        err,
    output logic [2:0]  err_cause,
    output logic        done,
    output logic [31:0] cycles,
    output logic [31:0] retired
);

    localparam logic [2:0] CauseNone     = 3'd0;
    localparam logic [2:0] CauseIllegal  = 3'd1;
    localparam logic [2:0] CauseMisalign = 3'd2;
    localparam logic [2:0] CauseHang     = 3'd3;
    localparam logic [2:0] CauseTimeout  = 3'd4;

    localparam logic [16:0] HangLim  = 17'(HANG_LIMIT);
    localparam logic [32:0] CycleLim = 33'(MAX_CYCLES);

    typedef enum logic [1:0] {StIdle, StRun, StHalted, StError} state_e;

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic [2:0]  cause_q, cause_d;
    logic        done_q, done_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] retired_q, retired_d;
    logic [15:0] hang_q, hang_d;

    logic hang_evt;
    logic timeout_evt;

    // Events are judged on the value the counter would take at this edge.
    assign hang_evt    = !retire_valid && (({1'b0, hang_q} + 17'd1) == HangLim);
    assign timeout_evt = (({1'b0, cycles_q} + 33'd1) == CycleLim);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        cause_d   = cause_q;
        done_d    = done_q;
        cycles_d  = cycles_q;
        retired_d = retired_q;
        hang_d    = hang_q;

        unique case (state_q)
            StIdle: begin
                state_d = StRun;
            end
            StRun: begin
                // Counters still advance on the edge that leaves RUN.
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (retire_valid && (retired_q != 32'hFFFF_FFFF)) begin
                    retired_d = retired_q + 32'd1;
                end
                if (retire_valid) begin
                    hang_d = 16'd0;
                end else if (hang_q != 16'hFFFF) begin
                    hang_d = hang_q + 16'd1;
                end

                // Priority: illegal > misalign > hang > timeout > halt.
                if (illegal_instr) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    cause_d = CauseIllegal;
                end else if (mem_misalign) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    cause_d = CauseMisalign;
                end else if (hang_evt) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    cause_d = CauseHang;
                end else if (timeout_evt) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    cause_d = CauseTimeout;
                end else if (halt) begin
                    state_d = StHalted;
                    done_d  = 1'b1;
                end
            end
            StHalted, StError: begin
                // Everything frozen until reset.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            err_q     <= 1'b0;
            cause_q   <= CauseNone;
            done_q    <= 1'b0;
            cycles_q  <= 32'd0;
            retired_q <= 32'd0;
            hang_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            cause_q   <= cause_d;
            done_q    <= done_d;
            cycles_q  <= cycles_d;
            retired_q <= retired_d;
            hang_q    <= hang_d;
        end
    end

`ifdef ERR_MON_PC_CAPTURE_EN
    logic [31:0] err_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pc_q <= 32'd0;
        end else if ((state_q == StRun) && (state_d == StError)) begin
            err_pc_q <= pc;
        end
    end

    assign err_pc = err_pc_q;
`endif

    assign err       = err_q;
    assign err_cause = cause_q;
    assign done      = done_q;
    assign cycles    = cycles_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_err_monitor.sv
module tb_err_monitor;

    logic        clk;
    logic        rst_n;
    logic        retire_valid;
    logic        halt;
    logic        illegal_instr;
    logic        mem_misalign;
    logic        err;
    logic [2:0]  err_cause;
    logic        done;
    logic [31:0] cycles;
    logic [31:0] retired;
`ifdef ERR_MON_PC_CAPTURE_EN
    logic [31:0] pc;
    logic [31:0] err_pc;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    err_monitor #(
        .HANG_LIMIT(4),
        .MAX_CYCLES(20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .retire_valid (retire_valid),
        .halt         (halt),
        .illegal_instr(illegal_instr),
        .mem_misalign (mem_misalign),
`ifdef ERR_MON_PC_CAPTURE_EN
        .pc           (pc),
        .err_pc       (err_pc),
`endif
        .err          (err),
        .err_cause    (err_cause),
        .done         (done),
        .cycles       (cycles),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_status(input string tag, input logic e, input logic [2:0] c,
                                input logic d, input logic [31:0] cy, input logic [31:0] rt);
        check({tag, ".err"}, {31'd0, err}, {31'd0, e});
        check({tag, ".cause"}, {29'd0, err_cause}, {29'd0, c});
        check({tag, ".done"}, {31'd0, done}, {31'd0, d});
        check({tag, ".cycles"}, cycles, cy);
        check({tag, ".retired"}, retired, rt);
    endtask

    task automatic clear_inputs();
        retire_valid  = 1'b0;
        halt          = 1'b0;
        illegal_instr = 1'b0;
        mem_misalign  = 1'b0;
`ifdef ERR_MON_PC_CAPTURE_EN
        pc            = 32'd0;
`endif
    endtask

    // Pulse reset between edges, check async clear, then take the IDLE->RUN edge.
    task automatic reset_and_start(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_status({tag, ".rst"}, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
`ifdef ERR_MON_PC_CAPTURE_EN
        check({tag, ".rst.err_pc"}, err_pc, 32'd0);
`endif
        rst_n = 1'b1;
        tick(1);
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        check_status("por", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick(1);
        check_status("idle2run", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);

        // Clean halt after 10 retiring cycles, halt cycle also retires.
        retire_valid = 1'b1;
        tick(10);
        check_status("run10", 1'b0, 3'd0, 1'b0, 32'd10, 32'd10);
        halt = 1'b1;
        tick(1);
        check_status("halt", 1'b0, 3'd0, 1'b1, 32'd11, 32'd11);
        clear_inputs();
        retire_valid  = 1'b1;
        illegal_instr = 1'b1;
        tick(3);
        check_status("halt_frozen", 1'b0, 3'd0, 1'b1, 32'd11, 32'd11);

        // Inputs sampled in IDLE are ignored (illegal held over the IDLE edge).
        #2;
        rst_n = 1'b0;
        #1;
        check_status("rst_halted", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick(1);
        check_status("idle_ignores", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        clear_inputs();

        // Hang: no retires from the start, HANG_LIMIT = 4.
        tick(3);
        check_status("hang_pre", 1'b0, 3'd0, 1'b0, 32'd3, 32'd0);
        tick(1);
        check_status("hang", 1'b1, 3'd3, 1'b0, 32'd4, 32'd0);
        tick(2);
        check_status("hang_frozen", 1'b1, 3'd3, 1'b0, 32'd4, 32'd0);

        // Reset out of ERROR; cycles restart from 0.
        reset_and_start("err_rst");
        check_status("err_rst_run", 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        tick(1);
        check_status("err_rst_cnt", 1'b0, 3'd0, 1'b0, 32'd1, 32'd0);

        // A retire every 4th cycle keeps the hang counter below the limit.
        reset_and_start("hclr");
        for (int i = 0; i < 3; i++) begin
            retire_valid = 1'b0;
            tick(3);
            retire_valid = 1'b1;
            tick(1);
        end
        check_status("hang_clear", 1'b0, 3'd0, 1'b0, 32'd12, 32'd3);
        clear_inputs();

        // Timeout at MAX_CYCLES = 20 with continuous retires.
        reset_and_start("tmo");
        retire_valid = 1'b1;
        tick(19);
        check_status("tmo_pre", 1'b0, 3'd0, 1'b0, 32'd19, 32'd19);
        tick(1);
        check_status("timeout", 1'b1, 3'd4, 1'b0, 32'd20, 32'd20);
        halt = 1'b1;
        tick(2);
        check_status("tmo_frozen", 1'b1, 3'd4, 1'b0, 32'd20, 32'd20);
        clear_inputs();

        // illegal + misalign + halt together: illegal wins.
        reset_and_start("all3");
        illegal_instr = 1'b1;
        mem_misalign  = 1'b1;
        halt          = 1'b1;
`ifdef ERR_MON_PC_CAPTURE_EN
        pc            = 32'h0000_0040;
`endif
        tick(1);
        check_status("prio_ill", 1'b1, 3'd1, 1'b0, 32'd1, 32'd0);
`ifdef ERR_MON_PC_CAPTURE_EN
        check("err_pc", err_pc, 32'h0000_0040);
        pc = 32'h0000_0080;
        tick(1);
        check("err_pc_hold", err_pc, 32'h0000_0040);
`endif
        clear_inputs();

        // misalign + halt: misalign wins.
        reset_and_start("mis");
        mem_misalign = 1'b1;
        halt         = 1'b1;
        tick(1);
        check("prio_mis.cause", {29'd0, err_cause}, 32'd2);
        check("prio_mis.done", {31'd0, done}, 32'd0);
        clear_inputs();

        // halt on the same edge a hang is detected: hang wins.
        reset_and_start("hh");
        tick(3);
        halt = 1'b1;
        tick(1);
        check_status("prio_hang", 1'b1, 3'd3, 1'b0, 32'd4, 32'd0);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
